battle_engine: RTL and testbench

- Resolves one auto-battle round per invocation and produces the battleDone/battleWin inputs consumed by the game-state controller.
- Launched when the controller leaves the plan state for the battle state.
- Latches both teams' attack/health stats, runs simultaneous front-pet clashes until one side is wiped or a round cap is hit, then reports the result.
- Exposes live health and front-pet indices for the battle-screen drawer.

---
 rtl/battle_engine.sv | 132 +++++++++++++
 tb/tb_battle_engine.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/battle_engine.sv
// Auto-battle resolver: latches both teams, runs simultaneous front-pet clashes, reports win/loss.
// Optional BATTLE_DELAY_EN inserts a STEP_CYCLES pacing wait before every clash.
module battle_engine #(
  parameter int N_PETS      = 3,
  parameter int STAT_W      = 4,
  parameter int MAX_ROUNDS  = 15,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       battle_start,
  input  logic [N_PETS*STAT_W-1:0]   player_atk,
  input  logic [N_PETS*STAT_W-1:0]   player_hp,
  input  logic [N_PETS*STAT_W-1:0]   opp_atk,
  input  logic [N_PETS*STAT_W-1:0]   opp_hp,
  output logic                       battleDone,
  output logic                       battleWin,
  output logic                       busy,
  output logic [N_PETS*STAT_W-1:0]   cur_player_hp,
  output logic [N_PETS*STAT_W-1:0]   cur_opp_hp,
  output logic [1:0]                 player_front,
  output logic [1:0]                 opp_front
);
  localparam int RW = $clog2(MAX_ROUNDS + 1);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, CLASH, DONE} state_t;

  state_t                          state;
  logic [N_PETS-1:0][STAT_W-1:0]   p_atk, p_hp, o_atk, o_hp;
  logic [RW-1:0]                   round;
  logic                            p_alive, o_alive;
  logic [STAT_W-1:0]               p_front_atk, o_front_atk;

`ifdef BATTLE_DELAY_EN
  localparam int CW = $clog2(STEP_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif

  function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] a, input logic [STAT_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  assign p_alive       = (p_hp != '0);
  assign o_alive       = (o_hp != '0);
  assign busy          = (state != IDLE);
  assign cur_player_hp = p_hp;
  assign cur_opp_hp    = o_hp;

  // Scan from the top slot down so the lowest live slot wins.
  always_comb begin
    player_front = 2'(N_PETS);
    opp_front    = 2'(N_PETS);
    for (int k = N_PETS - 1; k >= 0; k--) begin
      if (p_hp[k] != '0) player_front = 2'(k);
      if (o_hp[k] != '0) opp_front    = 2'(k);
    end
  end

  always_comb begin
    p_front_atk = '0;
    o_front_atk = '0;
    for (int k = 0; k < N_PETS; k++) begin
      if (player_front == 2'(k)) p_front_atk = p_atk[k];
      if (opp_front == 2'(k))    o_front_atk = o_atk[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      battleDone <= 1'b0;
      battleWin  <= 1'b0;
      p_atk      <= '0;
      p_hp       <= '0;
      o_atk      <= '0;
      o_hp       <= '0;
      round      <= '0;
`ifdef BATTLE_DELAY_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (battle_start) begin
          p_atk     <= player_atk;
          p_hp      <= player_hp;
          o_atk     <= opp_atk;
          o_hp      <= opp_hp;
          round     <= '0;
          battleWin <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          if (!p_alive || !o_alive || round == RW'(MAX_ROUNDS)) begin
            battleWin <= p_alive && !o_alive;
            state     <= DONE;
          end else begin
`ifdef BATTLE_DELAY_EN
            wait_cnt <= CW'(STEP_CYCLES - 1);
            state    <= WAIT;
`else
            state    <= CLASH;
`endif
          end
        end
`ifdef BATTLE_DELAY_EN
        WAIT: begin
          if (wait_cnt <= CW'(1)) state <= CLASH;
          else                    wait_cnt <= wait_cnt - 1'b1;
        end
`endif
        CLASH: begin
          // Both sides hit using pre-clash front values.
          for (int k = 0; k < N_PETS; k++) begin
            if (player_front == 2'(k)) p_hp[k] <= sat_sub(p_hp[k], o_front_atk);
            if (opp_front == 2'(k))    o_hp[k] <= sat_sub(o_hp[k], p_front_atk);
          end
          if (round != RW'(MAX_ROUNDS)) round <= round + 1'b1;
          state <= CHECK;
        end
        DONE: begin
          // Stay in DONE for the pulse cycle so busy covers it.
          if (!battleDone) battleDone <= 1'b1;
          else begin
            battleDone <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_battle_engine.sv
// Directed bench for battle_engine: clash arithmetic, fronts, round cap, empty team, reset and busy behaviour.
module tb_battle_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic        battle_start;
  logic [11:0] player_atk, player_hp, opp_atk, opp_hp;
  logic        battleDone, battleWin, busy;
  logic [11:0] cur_player_hp, cur_opp_hp;
  logic [1:0]  player_front, opp_front;
  int total = 0;
  int bad   = 0;

  battle_engine #(.N_PETS(3), .STAT_W(4), .MAX_ROUNDS(15), .STEP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .battle_start(battle_start),
    .player_atk(player_atk), .player_hp(player_hp), .opp_atk(opp_atk), .opp_hp(opp_hp),
    .battleDone(battleDone), .battleWin(battleWin), .busy(busy),
    .cur_player_hp(cur_player_hp), .cur_opp_hp(cur_opp_hp),
    .player_front(player_front), .opp_front(opp_front)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse battle_start for the next edge; returns just after that edge (cycle 0).
  task automatic start(input logic [11:0] pa, input logic [11:0] ph, input logic [11:0] oa, input logic [11:0] oh);
    player_atk = pa; player_hp = ph; opp_atk = oa; opp_hp = oh;
    battle_start = 1'b1;
    step();
    battle_start = 1'b0;
  endtask

  // Advances n edges; battleDone must appear only on the last one.
  task automatic run_to_done(input string tag, input int n, input logic win);
    int early = 0;
    for (int i = 1; i < n; i++) begin
      step();
      if (battleDone) early++;
    end
    chk({tag, "_early"}, early, 0);
    step();
    chk({tag, "_done"}, battleDone, 1);
    chk({tag, "_win"}, battleWin, win);
    chk({tag, "_busy"}, busy, 1);
    step();
    chk({tag, "_done_fall"}, battleDone, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int late;
    reset = 1'b1; battle_start = 1'b0;
    player_atk = '0; player_hp = '0; opp_atk = '0; opp_hp = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", battleDone, 0);
    chk("rst_win", battleWin, 0);
    chk("rst_pfront", player_front, 3);
    chk("rst_ofront", opp_front, 3);
    chk("rst_php", cur_player_hp, 0);
    reset = 1'b0;
    step();

`ifdef BATTLE_DELAY_EN
    start(12'h004, 12'h004, 12'h004, 12'h004);
    run_to_done("delay", 7, 1'b0);
    chk("delay_php", cur_player_hp, 12'h000);
`else
    // Two clashes: player 5->3->1, opponent 4->1->0.
    start(12'h003, 12'h005, 12'h002, 12'h004);
    chk("t1_busy", busy, 1);
    step(); step();
    chk("t1_php1", cur_player_hp, 12'h003);
    chk("t1_ohp1", cur_opp_hp, 12'h001);
    step(); step();
    chk("t1_php2", cur_player_hp, 12'h001);
    chk("t1_ohp2", cur_opp_hp, 12'h000);
    chk("t1_ofront", opp_front, 3);
    step();
    chk("t1_early", battleDone, 0);
    step();
    chk("t1_done", battleDone, 1);
    chk("t1_win", battleWin, 1);
    step();
    chk("t1_done_fall", battleDone, 0);
    chk("t1_idle", busy, 0);
    chk("t1_win_hold", battleWin, 1);

    start(12'h004, 12'h004, 12'h004, 12'h004);
    run_to_done("mutual", 4, 1'b0);
    chk("mutual_php", cur_player_hp, 12'h000);
    chk("mutual_ohp", cur_opp_hp, 12'h000);

    // Slot 0 dies on clash 1, slot 1 finishes the opponent on clash 2.
    start(12'h051, 12'h091, 12'h002, 12'h006);
    step(); step();
    chk("t3_pfront", player_front, 1);
    chk("t3_php1", cur_player_hp, 12'h090);
    chk("t3_ohp1", cur_opp_hp, 12'h005);
    step(); step();
    chk("t3_php2", cur_player_hp, 12'h070);
    chk("t3_ohp2", cur_opp_hp, 12'h000);
    run_to_done("t3", 2, 1'b1);

    start(12'h000, 12'h005, 12'h000, 12'h005);
    run_to_done("cap", 32, 1'b0);
    chk("cap_php", cur_player_hp, 12'h005);
    chk("cap_ohp", cur_opp_hp, 12'h005);

    start(12'h333, 12'h000, 12'h111, 12'h111);
    run_to_done("empty", 2, 1'b0);

    // Second start while busy must not reload stats or restart.
    start(12'h003, 12'h005, 12'h002, 12'h004);
    player_atk = 12'h004; player_hp = 12'h004; opp_atk = 12'h004; opp_hp = 12'h004;
    battle_start = 1'b1;
    step();
    battle_start = 1'b0;
    run_to_done("ignore", 5, 1'b1);
    chk("ignore_php", cur_player_hp, 12'h001);

    start(12'h003, 12'h005, 12'h002, 12'h004);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_php", cur_player_hp, 12'h000);
    chk("mrst_ohp", cur_opp_hp, 12'h000);
    chk("mrst_pfront", player_front, 3);
    chk("mrst_done", battleDone, 0);
    late = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (battleDone || busy) late++;
    end
    chk("mrst_quiet", late, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
